// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// Handshake: the memory raises mem_ready in the cycle it completes the access
// that the controller is requesting with MemRead/MemWrite. The controller
// holds the request steady until it sees mem_ready=1 at a rising edge.
interface multicycle_controller_if;
    logic [5:0] op;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;

    logic       illegal_op;
    logic [3:0] state;

    // Controller side: consumes opcode and memory handshake, drives controls.
    modport master (
        input  op,
        input  mem_ready,
        output PCWrite,
        output PCWriteCond,
        output IorD,
        output MemRead,
        output MemWrite,
        output IRWrite,
        output MemtoReg,
        output RegWrite,
        output RegDst,
        output ALUSrcA,
        output ALUSrcB,
        output ALUOp,
        output PCSource,
        output illegal_op,
        output state
    );

    // Datapath side: supplies opcode and memory handshake, obeys controls.
    modport slave (
        output op,
        output mem_ready,
        input  PCWrite,
        input  PCWriteCond,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        input  IRWrite,
        input  MemtoReg,
        input  RegWrite,
        input  RegDst,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUOp,
        input  PCSource,
        input  illegal_op,
        input  state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: fetch, decode, then per-instruction
// execute/memory/writeback states. Memory states optionally wait on
// mem_ready; addi decoding is optional. The current state code is exported
// for debug.
module multicycle_controller #(
    parameter int ADDI_EN = 1,  // 1: decode addi, 0: addi is illegal
    parameter int MEM_HS  = 1   // 1: memory states wait on mem_ready
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    // State codes are externally visible, so they are fixed values.
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic ADDI_ON = (ADDI_EN != 0);
    localparam logic HS_ON   = (MEM_HS != 0);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       ready;
    logic       op_legal;

    // Without the handshake every memory access completes in one cycle.
    assign ready = HS_ON ? bus.mem_ready : 1'b1;

    assign bus.state = state_q;

    // Opcode legality, only meaningful while in DECODE.
    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_RTYPE: op_legal = 1'b1;
            OP_LW:    op_legal = 1'b1;
            OP_SW:    op_legal = 1'b1;
            OP_BEQ:   op_legal = 1'b1;
            OP_J:     op_legal = 1'b1;
            OP_ADDI:  op_legal = ADDI_ON;
            default:  op_legal = 1'b0;
        endcase
    end

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE: state_d = S_EXEC;
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = ADDI_ON ? S_ADDIEX : S_FETCH;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            // Unused codes 12-15 recover to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    // Control outputs; everything is forced low while reset is held.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal_op  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    // PC and IR update only in the cycle the fetch completes.
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.PCWrite = ready;
                    bus.IRWrite = ready;
                end
                S_DECODE: begin
                    bus.ALUSrcB    = 2'b11;
                    bus.illegal_op = ~op_legal;
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    // Held for every wait cycle until memory accepts it.
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                S_ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    bus.RegWrite = 1'b1;
                end
                default: begin
                    bus.illegal_op = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: one default instance (addi on, handshake
// on) and one with addi off and handshake off. Each instruction is expanded
// into the sequence of states it should visit, then driven cycle by cycle.
module tb_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    multicycle_controller_if bus_a();
    multicycle_controller_if bus_b();

    multicycle_controller dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    multicycle_controller #(.ADDI_EN(0), .MEM_HS(0)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected state per cycle and the mem_ready to drive in that cycle.
    logic [3:0] exp_q[$];
    logic       mr_q[$];

    localparam logic [16:0] CTRL_ZERO = 17'd0;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input int sel, input logic [5:0] o, input logic mr);
        if (sel == 0) begin
            bus_a.op = o;
            bus_a.mem_ready = mr;
        end else begin
            bus_b.op = o;
            bus_b.mem_ready = mr;
        end
    endtask

    function automatic logic [3:0] get_state(input int sel);
        return (sel == 0) ? bus_a.state : bus_b.state;
    endfunction

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
    //  RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op}
    function automatic logic [16:0] get_ctrl(input int sel);
        if (sel == 0)
            return {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.IorD, bus_a.MemRead,
                    bus_a.MemWrite, bus_a.IRWrite, bus_a.MemtoReg, bus_a.RegWrite,
                    bus_a.RegDst, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp,
                    bus_a.PCSource, bus_a.illegal_op};
        return {bus_b.PCWrite, bus_b.PCWriteCond, bus_b.IorD, bus_b.MemRead,
                bus_b.MemWrite, bus_b.IRWrite, bus_b.MemtoReg, bus_b.RegWrite,
                bus_b.RegDst, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ALUOp,
                bus_b.PCSource, bus_b.illegal_op};
    endfunction

    function automatic bit is_legal(input logic [5:0] o, input bit addi_en);
        return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
               (o == 6'b000100) || (o == 6'b000010) || (addi_en && o == 6'b001000);
    endfunction

    // Control table keyed by the state name from the instruction timeline.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input bit mr,
                                             input bit mem_hs, input bit addi_en,
                                             input logic [5:0] o);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        bit m2r = 0, rw = 0, rdst = 0, srca = 0, ill = 0;
        logic [1:0] srcb = 2'b00, aluop = 2'b00, pcsrc = 2'b00;
        case (st)
            4'd0:  begin mrd = 1; srcb = 2'b01; pcw = mem_hs ? mr : 1'b1; irw = pcw; end
            4'd1:  begin srcb = 2'b11; ill = !is_legal(o, addi_en); end
            4'd2:  begin srca = 1; srcb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin srca = 1; aluop = 2'b10; end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            4'd9:  begin pcw = 1; pcsrc = 2'b10; end
            4'd10: begin srca = 1; srcb = 2'b10; end
            4'd11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, aluop, pcsrc, ill};
    endfunction

    task automatic push_wait(input logic [3:0] st, input int waits, input bit mem_hs);
        if (mem_hs) begin
            for (int k = 0; k < waits; k++) begin
                exp_q.push_back(st);
                mr_q.push_back(1'b0);
            end
            exp_q.push_back(st);
            mr_q.push_back(1'b1);
        end else begin
            // mem_ready held low: the access must still complete at once.
            exp_q.push_back(st);
            mr_q.push_back(1'b0);
        end
    endtask

    task automatic push_one(input logic [3:0] st);
        exp_q.push_back(st);
        mr_q.push_back(1'($urandom_range(0, 1)));
    endtask

    // Expand one instruction into its state timeline and run it. max_cycles
    // of 0 runs it to completion; otherwise it stops after that many cycles.
    task automatic run_instr(input int sel, input logic [5:0] o, input int wf,
                             input int wm, input int max_cycles);
        bit mem_hs = (sel == 0);
        bit addi_en = (sel == 0);
        int n;
        logic [5:0] drv_op;
        string tag;
        exp_q.delete();
        mr_q.delete();
        push_wait(4'd0, wf, mem_hs);
        push_one(4'd1);
        case (o)
            6'b000000: begin push_one(4'd6); push_one(4'd7); end
            6'b100011: begin push_one(4'd2); push_wait(4'd3, wm, mem_hs); push_one(4'd4); end
            6'b101011: begin push_one(4'd2); push_wait(4'd5, wm, mem_hs); end
            6'b000100: push_one(4'd8);
            6'b000010: push_one(4'd9);
            6'b001000: if (addi_en) begin push_one(4'd10); push_one(4'd11); end
            default: ;
        endcase
        n = exp_q.size();
        if (max_cycles > 0 && max_cycles < n) n = max_cycles;
        for (int i = 0; i < n; i++) begin
            // op only matters in DECODE/MEMADR; scramble it everywhere else.
            drv_op = (exp_q[i] == 4'd1 || exp_q[i] == 4'd2) ? o : 6'($urandom);
            drive(sel, drv_op, mr_q[i]);
            @(negedge clk);
            tag = $sformatf("dut%0d op=%b cyc%0d state", sel, o, i);
            check(tag, {13'd0, get_state(sel)}, {13'd0, exp_q[i]});
            tag = $sformatf("dut%0d op=%b cyc%0d ctrl", sel, o, i);
            check(tag, get_ctrl(sel), exp_ctrl(exp_q[i], mr_q[i], mem_hs, addi_en, drv_op));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        // Clock/reset: both instances held in reset for two edges.
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 6'b000000, 1'b1);
        drive(1, 6'b000000, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset a state", {13'd0, get_state(0)}, 17'd0);
        check("reset a ctrl", get_ctrl(0), CTRL_ZERO);
        check("reset b state", {13'd0, get_state(1)}, 17'd0);
        check("reset b ctrl", get_ctrl(1), CTRL_ZERO);
        @(posedge clk);
        #1;
        rst_a = 1'b0;

        // Directed instructions on the default instance.
        run_instr(0, 6'b000000, 0, 0, 0);  // R-type: 0,1,6,7
        run_instr(0, 6'b100011, 0, 3, 0);  // lw with 3 wait cycles in MEMRD
        run_instr(0, 6'b101011, 0, 0, 0);  // sw: 0,1,2,5
        run_instr(0, 6'b111111, 0, 0, 0);  // illegal
        run_instr(0, 6'b001000, 0, 0, 0);  // addi: 0,1,10,11
        run_instr(0, 6'b000100, 0, 0, 0);  // beq
        run_instr(0, 6'b000010, 0, 0, 0);  // j
        run_instr(0, 6'b100011, 2, 1, 0);  // lw with fetch stall

        // Reset while a store is stalled in MEMWR.
        run_instr(0, 6'b101011, 0, 3, 4);
        rst_a = 1'b1;
        drive(0, 6'b101011, 1'b0);
        @(negedge clk);
        check("mid-reset state held", {13'd0, get_state(0)}, 17'd5);
        check("mid-reset ctrl", get_ctrl(0), CTRL_ZERO);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset state", {13'd0, get_state(0)}, 17'd0);
        check("post-reset ctrl", get_ctrl(0), CTRL_ZERO);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        run_instr(0, 6'b000000, 0, 0, 0);

        // Randomized instruction stream on the default instance.
        for (int t = 0; t < 40; t++)
            run_instr(0, rand_op(), $urandom_range(0, 3), $urandom_range(0, 3), 0);

        // Second instance: addi off, handshake off.
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        run_instr(1, 6'b001000, 0, 0, 0);  // addi is illegal here
        run_instr(1, 6'b101011, 0, 0, 0);  // sw with mem_ready held low
        run_instr(1, 6'b100011, 0, 0, 0);  // lw with mem_ready held low
        run_instr(1, 6'b111111, 0, 0, 0);
        for (int t = 0; t < 20; t++)
            run_instr(1, rand_op(), 0, 0, 0);
        @(negedge clk);
        check("held reset a ctrl", get_ctrl(0), CTRL_ZERO);

        // Final report.
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ADDI_EN, default 1, meaning: 1 = opcode 6'b001000 (addi) decoded; 0 = addi treated as illegal.
REQ-002 Parameter MEM_HS, default 1, meaning: 1 = memory states wait on mem_ready; 0 = mem_ready ignored (treated as 1).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 op  input  6  instruction opcode from the instruction register.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  output  1 each  datapath controls.
REQ-008 ALUSrcB, ALUOp, PCSource  output  2 each  datapath selects.
REQ-009 illegal_op  output  1  one-cycle pulse on an undecodable opcode.
REQ-010 state  output  4  current state code, for debug.

Function
REQ-011 The state encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-012 Every output not listed for a state SHALL be 0 in that state.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=IRWrite=mem_ready (Mealy); stay while mem_ready=0, else go to DECODE.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by op: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX (ADDI_EN=1 only), any other->FETCH with illegal_op=1 in this cycle.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next is MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD: MemRead=1, IorD=1; stay while mem_ready=0, else go to MEMWB.
REQ-017 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; go to FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; stay while mem_ready=0, else go to FETCH; MemWrite SHALL remain high for every wait cycle.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; go to FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; go to FETCH.
REQ-021 JUMP: PCWrite=1, PCSource=10; go to FETCH.
REQ-022 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; go to FETCH.
REQ-023 Cycle counts with mem_ready held 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
REQ-024 op SHALL be sampled only in DECODE and MEMADR; changes of op in other states SHALL have no effect.

Reset
REQ-025 When reset=1 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-wait in MEMRD/MEMWR.
REQ-026 While reset=1, all control outputs and illegal_op SHALL be 0 combinationally; state SHALL show the register value.
REQ-027 On the first cycle after reset deasserts, the block SHALL be in FETCH with MemRead=1.

Verification
REQ-028 Reset for 2 cycles, then op=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-029 op=100011, mem_ready low for 3 cycles on entry to MEMRD -> state 3 held 4 cycles with MemRead=1, IorD=1; then state 4 with MemtoReg=1.
REQ-030 op=101011, mem_ready=1 -> states 0,1,2,5,0; MemWrite=1 for exactly one cycle; with MEM_HS=0, the same sequence occurs with mem_ready held 0.
REQ-031 op=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state 0; with ADDI_EN=0, op=001000 gives the same result; with ADDI_EN=1 it gives states 0,1,10,11,0.
REQ-032 reset asserted while in MEMWR with mem_ready=0 -> all outputs 0 that cycle; state 0 on the next edge; no further MemWrite.
REQ-033 op=000100 then 000010 -> BRANCH with PCWriteCond=1 and PCSource=01, then JUMP with PCWrite=1 and PCSource=10; each instruction takes 3 cycles.
